// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM state encoding, AXI burst/response codes,
// 4 KB boundary size and the byte-to-beat conversion helper.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K   = 4096;

  // ceil(len / 2**size_log2); the 33-bit sum keeps a full 32-bit length from wrapping
  function automatic logic [31:0] bytes_to_beats(input logic [31:0] len,
                                                 input int unsigned size_log2);
    logic [32:0] w_sum;
    w_sum = {1'b0, len} + ((33'd1 << size_log2) - 33'd1);
    return 32'(w_sum >> size_log2);
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst length: min(max burst, beats remaining, beats left before
// the next 4 KB boundary). Shared by the read and write masters.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned SIZE_LOG2 = 2
) (
  input  logic [11:0] i_addr_ofs,
  input  logic [31:0] i_beats_left,
  output logic [8:0]  o_burst
);

  logic [12:0] w_room_bytes;
  logic [31:0] w_room_beats;
  logic [31:0] w_min;

  always_comb begin
    w_room_bytes = 13'(BOUNDARY_4K) - {1'b0, i_addr_ofs};
    w_room_beats = 32'(w_room_bytes >> SIZE_LOG2);
    w_min        = 32'(MAX_BURST);
    if (i_beats_left < w_min) w_min = i_beats_left;
    if (w_room_beats < w_min) w_min = w_room_beats;
    o_burst      = 9'(w_min);
  end

endmodule

// File: rtl/dma_read_master.sv
// AXI4 read master: fetches a byte range as 4 KB-safe INCR bursts into the data FIFO.
// Optional DMA_RD_ERR_ABORT_EN: a non-OKAY RRESP stops the transfer after the current burst.
module dma_read_master
  import dma_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_read_done,
  output logic                          o_error,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned AW        = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BPB       = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2 = $clog2(BPB);

  dma_state_e      r_state;
  dma_state_e      w_next_state;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_beats_left;
  logic [7:0]      r_arlen;
  logic [7:0]      r_beat_cnt;
  logic            r_read_done;
  logic            r_error;

  logic [8:0]      w_burst;
  logic [31:0]     w_start_beats;
  logic [31:0]     w_beats_after;
  logic [AW-1:0]   w_burst_bytes;
  logic            w_start_acc;
  logic            w_hs;
  logic            w_last_beat;
  logic            w_burst_end;
  logic            w_resp_err;
  logic            w_beat_err;
  logic            w_abort;
  logic            w_wr_block;

  assign w_start_beats = bytes_to_beats(i_total_len, SIZE_LOG2);
  assign w_start_acc   = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hs          = (r_state == S_DATA) && m_axi_rvalid && !i_fifo_full;
  assign w_last_beat   = (r_beat_cnt == r_arlen);
  assign w_burst_end   = w_hs && w_last_beat;
  assign w_resp_err    = w_hs && (m_axi_rresp != AXI_RESP_OKAY);
  // A misplaced or missing RLAST is flagged, but the burst length is owned by our counter
  assign w_beat_err    = w_resp_err || (w_hs && (m_axi_rlast != w_last_beat));
  assign w_beats_after = r_beats_left - (32'(r_arlen) + 32'd1);
  assign w_burst_bytes = (AW'(r_arlen) + AW'(1)) << SIZE_LOG2;

`ifdef DMA_RD_ERR_ABORT_EN
  logic r_abort;

  // Remembers an error beat so the rest of the burst is drained without FIFO writes
  always_ff @(posedge clk) begin
    if (reset)            r_abort <= 1'b0;
    else if (w_start_acc) r_abort <= 1'b0;
    else if (w_resp_err)  r_abort <= 1'b1;
  end

  assign w_abort    = r_abort || w_resp_err;
  assign w_wr_block = r_abort;
`else
  assign w_abort    = 1'b0;
  assign w_wr_block = 1'b0;
`endif

  dma_burst_calc #(
    .MAX_BURST (C_M_AXI_BURST_LEN),
    .SIZE_LOG2 (SIZE_LOG2)
  ) u_burst_calc (
    .i_addr_ofs   (r_addr[11:0]),
    .i_beats_left (r_beats_left),
    .o_burst      (w_burst)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next_state = (w_start_beats == 32'd0) ? S_DONE : S_CALC;
      S_CALC:         w_next_state = S_ADDR;
      S_ADDR:         if (m_axi_arready) w_next_state = S_DATA;
      S_DATA:         if (w_burst_end)
                        w_next_state = (w_beats_after == 32'd0 || w_abort) ? S_DONE : S_CALC;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // Handshake-facing outputs; RREADY must follow the FIFO full flag in the same cycle
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    o_fifo_wr_en  = 1'b0;
    unique case (r_state)
      S_ADDR:  m_axi_arvalid = 1'b1;
      S_DATA: begin
        m_axi_rready = !i_fifo_full;
        o_fifo_wr_en = w_hs && !w_wr_block;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_beats_left <= '0;
      r_arlen      <= '0;
      r_beat_cnt   <= '0;
      r_read_done  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_addr       <= i_src_addr;
        r_beats_left <= w_start_beats;
        r_error      <= 1'b0;
      end
      if (r_state == S_CALC) begin
        r_arlen    <= 8'(w_burst - 9'd1);
        r_beat_cnt <= '0;
      end
      if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (w_beat_err) r_error <= 1'b1;
      end
      if (w_burst_end) begin
        r_addr       <= r_addr + w_burst_bytes;
        r_beats_left <= w_beats_after;
      end
      r_read_done <= (w_next_state == S_DONE);
    end
  end

  assign o_read_done    = r_read_done;
  assign o_error        = r_error;
  assign o_fifo_wr_data = m_axi_rdata;
  assign m_axi_araddr   = r_addr;
  assign m_axi_arlen    = r_arlen;
  assign m_axi_arsize   = 3'(SIZE_LOG2);
  assign m_axi_arburst  = AXI_BURST_INCR;

endmodule
